// File: rtl/cache_ctrl.sv
// Controller for a direct-mapped, write-back, write-allocate cache: owns tag/valid/dirty state,
// sequences block write-back and fetch with memory, and strobes an external data array.
module cache_ctrl #(
  parameter int ADDR_W      = 10,
  parameter int NUM_LINES   = 4,
  parameter int BLOCK_WORDS = 4,
  parameter int CNT_W       = 16,
  localparam int IDX_W      = $clog2(NUM_LINES),
  localparam int OFF_W      = 2 + $clog2(BLOCK_WORDS),
  localparam int TAG_W      = ADDR_W - OFF_W - IDX_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  output logic [IDX_W-1:0]  arr_index,
  output logic [OFF_W-3:0]  arr_word,
  output logic              arr_we_word,
  output logic              arr_fill,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE} state_t;

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic                 we_q, we_d;
  logic                 from_alloc_q, from_alloc_d;
  logic                 mem_req_q, mem_req_d;
  logic                 mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [NUM_LINES-1:0] dirty_q, dirty_d;
  logic [TAG_W-1:0]     tag_q [NUM_LINES];
  logic [TAG_W-1:0]     tag_d [NUM_LINES];
  logic [CNT_W-1:0]     hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]     miss_cnt_q, miss_cnt_d;

  logic [TAG_W-1:0]     req_tag;
  logic [IDX_W-1:0]     req_idx;
  logic [OFF_W-3:0]     req_word;
  logic [TAG_W-1:0]     line_tag;
  logic                 hit;

  assign req_tag  = addr_q[ADDR_W-1:OFF_W+IDX_W];
  assign req_idx  = addr_q[OFF_W+IDX_W-1:OFF_W];
  assign req_word = addr_q[OFF_W-1:2];
  assign line_tag = tag_q[req_idx];
  assign hit      = valid_q[req_idx] && (line_tag == req_tag);

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign arr_index = req_idx;
  assign arr_word  = req_word;
  assign hit_cnt   = hit_cnt_q;
  assign miss_cnt  = miss_cnt_q;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    we_d         = we_q;
    from_alloc_d = from_alloc_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    tag_d        = tag_q;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    cpu_ready    = 1'b0;
    arr_we_word  = 1'b0;
    arr_fill     = 1'b0;

    case (state_q)
      IDLE: begin
        if (cpu_req) begin
          addr_d       = cpu_addr;
          we_d         = cpu_we;
          from_alloc_d = 1'b0;
          state_d      = COMPARE;
        end
      end
      COMPARE: begin
        if (hit) begin
          cpu_ready = 1'b1;
          if (we_q) begin
            arr_we_word      = 1'b1;
            dirty_d[req_idx] = 1'b1;
          end
          // The re-compare after a fill completes a miss; it is not a hit of its own.
          if (!from_alloc_q && (hit_cnt_q != {CNT_W{1'b1}})) begin
            hit_cnt_d = hit_cnt_q + 1'b1;
          end
          state_d = IDLE;
        end else begin
          if (miss_cnt_q != {CNT_W{1'b1}}) begin
            miss_cnt_d = miss_cnt_q + 1'b1;
          end
          mem_req_d = 1'b1;
          if (valid_q[req_idx] && dirty_q[req_idx]) begin
            mem_we_d   = 1'b1;
            mem_addr_d = {line_tag, req_idx, {OFF_W{1'b0}}};
            state_d    = WRITEBACK;
          end else begin
            mem_we_d   = 1'b0;
            mem_addr_d = {req_tag, req_idx, {OFF_W{1'b0}}};
            state_d    = ALLOCATE;
          end
        end
      end
      WRITEBACK: begin
        if (mem_ready) begin
          dirty_d[req_idx] = 1'b0;
          mem_we_d         = 1'b0;
          mem_addr_d       = {req_tag, req_idx, {OFF_W{1'b0}}};
          state_d          = ALLOCATE;
        end
      end
      ALLOCATE: begin
        if (mem_ready) begin
          arr_fill         = 1'b1;
          valid_d[req_idx] = 1'b1;
          dirty_d[req_idx] = 1'b0;
          tag_d[req_idx]   = req_tag;
          mem_req_d        = 1'b0;
          from_alloc_d     = 1'b1;
          state_d          = COMPARE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      we_q         <= 1'b0;
      from_alloc_q <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      valid_q      <= '0;
      dirty_q      <= '0;
      for (int i = 0; i < NUM_LINES; i++) tag_q[i] <= '0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      from_alloc_q <= from_alloc_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      valid_q      <= valid_d;
      dirty_q      <= dirty_d;
      tag_q        <= tag_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl: each task runs one scenario cycle by cycle and checks
// outputs against hand-computed values at the falling edge.
module tb_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we;
  logic [9:0]  cpu_addr;
  logic        cpu_ready, mem_req, mem_we;
  logic [9:0]  mem_addr;
  logic        mem_ready;
  logic [1:0]  arr_index;
  logic [1:0]  arr_word;
  logic        arr_we_word, arr_fill;
  logic [15:0] hit_cnt, miss_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cache_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_ready(cpu_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_ready(mem_ready),
    .arr_index(arr_index), .arr_word(arr_word), .arr_we_word(arr_we_word), .arr_fill(arr_fill),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  // Start of a cycle: just after the rising edge, where inputs are driven.
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  // Mid-cycle sample point.
  task automatic smp();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; mem_ready = 1'b0;
    #2 rst_n = 1'b0;
    cyc(); cyc(); smp();
    checks++; if (cpu_ready !== 1'b0) begin errors++; $display("FAIL rst_cpu_ready got=%0h exp=0", cpu_ready); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req got=%0h exp=0", mem_req); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we got=%0h exp=0", mem_we); end
    checks++; if (mem_addr !== 10'h000) begin errors++; $display("FAIL rst_mem_addr got=%0h exp=0", mem_addr); end
    checks++; if (arr_we_word !== 1'b0 || arr_fill !== 1'b0) begin errors++; $display("FAIL rst_arr got=%0b%0b exp=00", arr_we_word, arr_fill); end
    checks++; if (hit_cnt !== 16'd0 || miss_cnt !== 16'd0) begin errors++; $display("FAIL rst_cnt got=%0d/%0d exp=0/0", hit_cnt, miss_cnt); end
    cyc(); rst_n = 1'b1;
    $display("txn reset done");
  endtask

  task automatic test_cold_read();
    cyc(); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h014; smp();
    checks++; if (cpu_ready !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL t1_c0 got=%0b%0b exp=00", cpu_ready, mem_req); end
    cyc(); smp();
    checks++; if (cpu_ready !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL t1_c1 got=%0b%0b exp=00", cpu_ready, mem_req); end
    cyc(); smp();
    checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0) begin errors++; $display("FAIL t1_fetch_req got=%0b%0b exp=10", mem_req, mem_we); end
    checks++; if (mem_addr !== 10'h010) begin errors++; $display("FAIL t1_fetch_addr got=%0h exp=010", mem_addr); end
    checks++; if (miss_cnt !== 16'd1) begin errors++; $display("FAIL t1_miss_cnt got=%0d exp=1", miss_cnt); end
    for (int i = 0; i < 2; i++) begin
      cyc(); smp();
      checks++; if (mem_req !== 1'b1 || arr_fill !== 1'b0 || cpu_ready !== 1'b0) begin errors++; $display("FAIL t1_wait got=%0b%0b%0b exp=100", mem_req, arr_fill, cpu_ready); end
    end
    cyc(); mem_ready = 1'b1; smp();
    checks++; if (arr_fill !== 1'b1 || arr_index !== 2'd1 || cpu_ready !== 1'b0) begin errors++; $display("FAIL t1_fill got=%0b idx=%0d rdy=%0b exp=1 idx=1 rdy=0", arr_fill, arr_index, cpu_ready); end
    cyc(); mem_ready = 1'b0; smp();
    checks++; if (cpu_ready !== 1'b1 || mem_req !== 1'b0 || arr_we_word !== 1'b0) begin errors++; $display("FAIL t1_ready got=%0b%0b%0b exp=100", cpu_ready, mem_req, arr_we_word); end
    cyc(); cpu_req = 1'b0; smp();
    checks++; if (hit_cnt !== 16'd0 || miss_cnt !== 16'd1) begin errors++; $display("FAIL t1_cnt got=%0d/%0d exp=0/1", hit_cnt, miss_cnt); end
    $display("txn read 0x014 (cold miss) done");
  endtask

  task automatic test_read_hit();
    cyc(); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h014; smp();
    cyc(); smp();
    checks++; if (cpu_ready !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("FAIL t2_hit got=%0b%0b exp=10", cpu_ready, mem_req); end
    cyc(); cpu_req = 1'b0; smp();
    checks++; if (hit_cnt !== 16'd1 || mem_req !== 1'b0) begin errors++; $display("FAIL t2_cnt got=%0d req=%0b exp=1 req=0", hit_cnt, mem_req); end
    $display("txn read 0x014 (hit) done");
  endtask

  task automatic test_write_hit();
    cyc(); cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h018; smp();
    cyc(); smp();
    checks++; if (cpu_ready !== 1'b1 || arr_we_word !== 1'b1) begin errors++; $display("FAIL t3_wr got=%0b%0b exp=11", cpu_ready, arr_we_word); end
    checks++; if (arr_word !== 2'd2 || arr_index !== 2'd1) begin errors++; $display("FAIL t3_sel got=%0d/%0d exp=1/2", arr_index, arr_word); end
    cyc(); cpu_req = 1'b0; smp();
    checks++; if (dut.dirty_q[1] !== 1'b1) begin errors++; $display("FAIL t3_dirty got=%0b exp=1", dut.dirty_q[1]); end
    checks++; if (hit_cnt !== 16'd2) begin errors++; $display("FAIL t3_hit_cnt got=%0d exp=2", hit_cnt); end
    $display("txn write 0x018 (hit) done");
  endtask

  task automatic test_dirty_miss();
    cyc(); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h054; smp();
    cyc(); smp();
    checks++; if (cpu_ready !== 1'b0) begin errors++; $display("FAIL t4_c1 got=%0b exp=0", cpu_ready); end
    cyc(); smp();
    checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 10'h010) begin errors++; $display("FAIL t4_wb got=%0b%0b addr=%0h exp=11 addr=010", mem_req, mem_we, mem_addr); end
    cyc(); mem_ready = 1'b1; smp();
    checks++; if (arr_fill !== 1'b0 || cpu_ready !== 1'b0) begin errors++; $display("FAIL t4_wb_done got=%0b%0b exp=00", arr_fill, cpu_ready); end
    cyc(); mem_ready = 1'b0; smp();
    checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 10'h050) begin errors++; $display("FAIL t4_fetch got=%0b%0b addr=%0h exp=10 addr=050", mem_req, mem_we, mem_addr); end
    checks++; if (dut.dirty_q[1] !== 1'b0) begin errors++; $display("FAIL t4_clean got=%0b exp=0", dut.dirty_q[1]); end
    cyc(); mem_ready = 1'b1; smp();
    checks++; if (arr_fill !== 1'b1) begin errors++; $display("FAIL t4_fill got=%0b exp=1", arr_fill); end
    cyc(); mem_ready = 1'b0; smp();
    checks++; if (cpu_ready !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("FAIL t4_ready got=%0b%0b exp=10", cpu_ready, mem_req); end
    cyc(); cpu_req = 1'b0; smp();
    checks++; if (miss_cnt !== 16'd2 || hit_cnt !== 16'd2) begin errors++; $display("FAIL t4_cnt got=%0d/%0d exp=2/2", hit_cnt, miss_cnt); end
    $display("txn read 0x054 (dirty miss) done");
  endtask

  task automatic test_write_miss();
    cyc(); cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h06C; smp();
    cyc(); smp();
    cyc(); mem_ready = 1'b1; smp();
    checks++; if (mem_addr !== 10'h060 || mem_we !== 1'b0 || mem_req !== 1'b1) begin errors++; $display("FAIL t5_fetch got=%0h we=%0b req=%0b exp=060 we=0 req=1", mem_addr, mem_we, mem_req); end
    checks++; if (arr_fill !== 1'b1 || arr_we_word !== 1'b0 || arr_index !== 2'd2) begin errors++; $display("FAIL t5_fill got=%0b%0b idx=%0d exp=10 idx=2", arr_fill, arr_we_word, arr_index); end
    cyc(); mem_ready = 1'b0; smp();
    checks++; if (cpu_ready !== 1'b1 || arr_we_word !== 1'b1 || arr_word !== 2'd3) begin errors++; $display("FAIL t5_wr got=%0b%0b word=%0d exp=11 word=3", cpu_ready, arr_we_word, arr_word); end
    cyc(); cpu_req = 1'b0; smp();
    checks++; if (dut.dirty_q[2] !== 1'b1) begin errors++; $display("FAIL t5_dirty got=%0b exp=1", dut.dirty_q[2]); end
    checks++; if (hit_cnt !== 16'd2 || miss_cnt !== 16'd3) begin errors++; $display("FAIL t5_cnt got=%0d/%0d exp=2/3", hit_cnt, miss_cnt); end
    $display("txn write 0x06C (clean miss) done");
  endtask

  task automatic test_reset_abort();
    cyc(); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h094; smp();
    cyc(); smp();
    cyc(); smp();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 10'h090) begin errors++; $display("FAIL t6_fetch got=%0b addr=%0h exp=1 addr=090", mem_req, mem_addr); end
    cyc(); rst_n = 1'b0; cpu_req = 1'b0; #1;
    checks++; if (mem_req !== 1'b0 || mem_addr !== 10'h000) begin errors++; $display("FAIL t6_abort got=%0b addr=%0h exp=0 addr=000", mem_req, mem_addr); end
    cyc(); cyc(); rst_n = 1'b1; smp();
    checks++; if (hit_cnt !== 16'd0 || miss_cnt !== 16'd0 || dut.dirty_q !== 4'b0000) begin errors++; $display("FAIL t6_cleared got=%0d/%0d dirty=%0b exp=0/0 dirty=0", hit_cnt, miss_cnt, dut.dirty_q); end
    cyc(); cpu_req = 1'b1; cpu_addr = 10'h054; smp();
    cyc(); smp();
    checks++; if (cpu_ready !== 1'b0) begin errors++; $display("FAIL t6_rehit got=%0b exp=0", cpu_ready); end
    cyc(); smp();
    checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 10'h050) begin errors++; $display("FAIL t6_refetch got=%0b%0b addr=%0h exp=10 addr=050", mem_req, mem_we, mem_addr); end
    cyc(); mem_ready = 1'b1; smp();
    cyc(); mem_ready = 1'b0; smp();
    checks++; if (cpu_ready !== 1'b1) begin errors++; $display("FAIL t6_ready got=%0b exp=1", cpu_ready); end
    $display("txn reset abort + read 0x054 (miss) done");
  endtask

  task automatic test_back_to_back();
    // cpu_req is still high from the previous request; the next one starts in the IDLE cycle.
    cyc(); cpu_addr = 10'h058; smp();
    checks++; if (cpu_ready !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL b2b_idle got=%0b%0b exp=00", cpu_ready, mem_req); end
    cyc(); smp();
    checks++; if (cpu_ready !== 1'b1 || arr_word !== 2'd2 || arr_index !== 2'd1) begin errors++; $display("FAIL b2b_ready got=%0b sel=%0d/%0d exp=1 sel=1/2", cpu_ready, arr_index, arr_word); end
    cyc(); cpu_addr = 10'h054; smp();
    cyc(); cpu_req = 1'b0; smp();
    checks++; if (cpu_ready !== 1'b1) begin errors++; $display("FAIL b2b_third got=%0b exp=1", cpu_ready); end
    cyc(); smp();
    checks++; if (hit_cnt !== 16'd2 || miss_cnt !== 16'd1) begin errors++; $display("FAIL b2b_cnt got=%0d/%0d exp=2/1", hit_cnt, miss_cnt); end
    $display("txn back-to-back reads 0x058, 0x054 done");
  endtask

  initial begin
    test_reset();
    test_cold_read();
    test_read_hit();
    test_write_hit();
    test_dirty_miss();
    test_write_miss();
    test_reset_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
